// File: rtl/spike_frame_buffer.sv
// Spike frame buffer: captures T_STEPS spike vectors, then replays them in time-step order over valid/ready.
// Optional per-channel spike counters are built when SPIKE_COUNT_EN is defined.
//
// state | meaning
// IDLE  | empty, waiting for the first vector of a sequence
// FILL  | capturing vectors 1..T_STEPS-1
// DRAIN | all frames held, replaying to consumer; new input is dropped
module spike_frame_buffer #(
    parameter int DATA_W  = 16,
    parameter int T_STEPS = 30,
    parameter int IDX_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic [DATA_W-1:0] frame_out,
    output logic              frame_out_valid,
    input  logic              frame_out_ready,
    output logic [IDX_W-1:0]  frame_idx,
    output logic              full,
    output logic              done,
    output logic              overflow
`ifdef SPIKE_COUNT_EN
    ,
    output logic [DATA_W*IDX_W-1:0] spike_cnt,
    output logic                    spike_cnt_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(T_STEPS - 1);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  wr_ptr, wr_nxt;
    logic [IDX_W-1:0]  rd_ptr, rd_nxt;
    logic              full_nxt, done_nxt, ovf_nxt, mem_we;
    logic [DATA_W-1:0] mem [T_STEPS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            full     <= full_nxt;
            done     <= done_nxt;
            overflow <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        full_nxt  = full;
        done_nxt  = 1'b0;
        ovf_nxt   = overflow;
        mem_we    = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            wr_nxt    = '0;
            rd_nxt    = '0;
            full_nxt  = 1'b0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_in_valid) begin
                        mem_we    = 1'b1;
                        wr_nxt    = ONE;
                        ovf_nxt   = 1'b0;
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    if (data_in_valid) begin
                        mem_we = 1'b1;
                        // wr_ptr parks at the last index; it is rewound when the drain completes
                        if (wr_ptr == LAST) begin
                            state_nxt = DRAIN;
                            full_nxt  = 1'b1;
                            rd_nxt    = '0;
                        end else begin
                            wr_nxt = wr_ptr + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (data_in_valid) ovf_nxt = 1'b1;
                    if (frame_out_ready) begin
                        if (rd_ptr == LAST) begin
                            done_nxt  = 1'b1;
                            full_nxt  = 1'b0;
                            wr_nxt    = '0;
                            rd_nxt    = '0;
                            state_nxt = IDLE;
                        end else begin
                            rd_nxt = rd_ptr + ONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Frame storage has no reset; contents are only observable after being written
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr] <= data_in;
    end

    assign frame_out       = mem[rd_ptr];
    assign frame_out_valid = (state == DRAIN);
    assign frame_idx       = rd_ptr;

`ifdef SPIKE_COUNT_EN
    logic [IDX_W-1:0] cnt [DATA_W];
    logic             cnt_load, cnt_acc, cnt_set;

    assign cnt_load = !clear && (state == IDLE) && data_in_valid;
    assign cnt_acc  = !clear && (state == FILL) && data_in_valid;
    assign cnt_set  = cnt_acc && (wr_ptr == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DATA_W; i++) cnt[i] <= '0;
            spike_cnt_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DATA_W; i++) cnt[i] <= '0;
            spike_cnt_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DATA_W; i++) begin
                if (cnt_load)     cnt[i] <= IDX_W'(data_in[i]);
                else if (cnt_acc) cnt[i] <= cnt[i] + IDX_W'(data_in[i]);
            end
            if (cnt_load)     spike_cnt_valid <= 1'b0;
            else if (cnt_set) spike_cnt_valid <= 1'b1;
        end
    end

    always_comb begin
        spike_cnt = '0;
        for (int i = 0; i < DATA_W; i++) spike_cnt[i*IDX_W +: IDX_W] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_spike_frame_buffer.sv
// Bench for spike_frame_buffer: queue-based reference model checked every cycle, directed scenarios,
// then randomized traffic. Define SPIKE_COUNT_EN to also exercise the spike counters.
module tb_spike_frame_buffer;
    localparam int DATA_W = 16;
    localparam int T      = 30;
    localparam int IDX_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              din_v = 1'b0;
    logic              rdy = 1'b0;
    logic [DATA_W-1:0] frame_out;
    logic              frame_out_valid;
    logic [IDX_W-1:0]  frame_idx;
    logic              full, done, overflow;
`ifdef SPIKE_COUNT_EN
    logic [DATA_W*IDX_W-1:0] spike_cnt;
    logic                    spike_cnt_valid;
`endif

    spike_frame_buffer #(.DATA_W(DATA_W), .T_STEPS(T), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .data_in(din), .data_in_valid(din_v),
        .frame_out(frame_out), .frame_out_valid(frame_out_valid), .frame_out_ready(rdy),
        .frame_idx(frame_idx), .full(full), .done(done), .overflow(overflow)
`ifdef SPIKE_COUNT_EN
        , .spike_cnt(spike_cnt), .spike_cnt_valid(spike_cnt_valid)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a sequence is a queue of captured frames; replay index counts delivered frames
    logic [DATA_W-1:0] m_frames[$];
    logic [DATA_W-1:0] m_snap[$];
    int m_sent = 0;
    bit m_ovf  = 1'b0;
    bit m_done = 1'b0;
    bit m_cvld = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_frames.delete();
            m_snap.delete();
            m_sent = 0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
            m_cvld = 1'b0;
        end else begin
            m_done = 1'b0;
            if (clear) begin
                m_frames.delete();
                m_snap.delete();
                m_sent = 0;
                m_ovf  = 1'b0;
                m_cvld = 1'b0;
            end else if (m_frames.size() < T) begin
                if (din_v) begin
                    if (m_frames.size() == 0) begin
                        m_ovf  = 1'b0;
                        m_cvld = 1'b0;
                    end
                    m_frames.push_back(din);
                    if (m_frames.size() == T) begin
                        m_snap = m_frames;
                        m_cvld = 1'b1;
                    end
                end
            end else begin
                if (din_v) m_ovf = 1'b1;
                if (rdy) begin
                    m_sent++;
                    if (m_sent == T) begin
                        m_frames.delete();
                        m_sent = 0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    function automatic int exp_cnt(input int ch);
        int c = 0;
        foreach (m_snap[k]) c += int'(m_snap[k][ch]);
        return c;
    endfunction

    always @(negedge clk) begin
        bit ev;
        ev = (m_frames.size() == T);
        cmp("valid", frame_out_valid, ev);
        cmp("full", full, ev);
        cmp("done", done, m_done);
        cmp("overflow", overflow, m_ovf);
        cmp("frame_idx", frame_idx, ev ? m_sent : 0);
        if (ev) cmp("frame_out", frame_out, m_frames[m_sent]);
`ifdef SPIKE_COUNT_EN
        cmp("cnt_valid", spike_cnt_valid, m_cvld);
        if (m_cvld)
            for (int ch = 0; ch < DATA_W; ch++)
                cmp("spike_cnt", spike_cnt[ch*IDX_W +: IDX_W], exp_cnt(ch));
`endif
    end

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            din   = DATA_W'($urandom);
            din_v = 1'b1;
            @(negedge clk);
        end
        din_v = 1'b0;
    endtask

    task automatic drain_all(input string name);
        int n = 0;
        rdy = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        cmp(name, done, 1'b1);
    endtask

    initial begin
        int xfers;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("reset_valid", frame_out_valid, 1'b0);
        cmp("reset_idx", frame_idx, 0);

        // back-to-back fill, one-hot walking pattern, consumer always ready
        rdy = 1'b1;
        for (int t = 0; t < T; t++) begin
            din   = DATA_W'(1) << (t % 16);
            din_v = 1'b1;
            @(negedge clk);
        end
        din_v = 1'b0;
        cmp("t1_valid_rise", frame_out_valid, 1'b1);
        for (int k = 0; k < T; k++) begin
            cmp("t1_idx", frame_idx, k);
            cmp("t1_frame", frame_out, 32'(16'h0001 << (k % 16)));
            @(negedge clk);
        end
        cmp("t1_done", done, 1'b1);
        @(negedge clk);
        cmp("t1_done_once", done, 1'b0);
        cmp("t1_idle", frame_out_valid, 1'b0);

        // back-pressure pattern 1,0,0 repeating
        rdy = 1'b0;
        fill_rand(T);
        xfers = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            rdy = (i % 3 == 0);
            if (frame_out_valid && rdy) xfers++;
            @(negedge clk);
        end
        cmp("t2_done", done, 1'b1);
        cmp("t2_xfers", xfers, T);

        // overflow while holding frames
        rdy = 1'b0;
        for (int t = 0; t < T; t++) begin
            din   = DATA_W'(16'h0100 + t);
            din_v = 1'b1;
            @(negedge clk);
        end
        din   = 16'hFFFF;
        din_v = 1'b1;
        @(negedge clk);
        din_v = 1'b0;
        cmp("t3_overflow", overflow, 1'b1);
        cmp("t3_frame_kept", frame_out, 16'h0100);
        drain_all("t3_done");
        cmp("t3_ovf_sticky", overflow, 1'b1);
        din   = 16'h1234;
        din_v = 1'b1;
        @(negedge clk);
        din_v = 1'b0;
        cmp("t3_ovf_cleared", overflow, 1'b0);

        // clear mid-fill (12th capture already counted above as the first)
        fill_rand(11);
        clear = 1'b1;
        din_v = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        din_v = 1'b0;
        cmp("t4_full", full, 1'b0);
        cmp("t4_done", done, 1'b0);
        fill_rand(T);
        drain_all("t4_replay_done");

        // async reset mid-drain at frame 7
        rdy = 1'b0;
        fill_rand(T);
        rdy = 1'b1;
        for (int i = 0; i < 40 && frame_idx != 7; i++) @(negedge clk);
        cmp("t5_reach7", frame_idx, 7);
        rdy = 1'b0;
        #2 rst = 1'b1;
        #1;
        cmp("t5_valid", frame_out_valid, 1'b0);
        cmp("t5_full", full, 1'b0);
        cmp("t5_idx", frame_idx, 0);
        cmp("t5_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("t5_no_done", done, 1'b0);

`ifdef SPIKE_COUNT_EN
        for (int t = 0; t < T; t++) begin
            din   = 16'hAAAA;
            din_v = 1'b1;
            @(negedge clk);
        end
        din_v = 1'b0;
        cmp("t6_cnt_valid", spike_cnt_valid, 1'b1);
        cmp("t6_cnt_odd", spike_cnt[1*IDX_W +: IDX_W], 30);
        cmp("t6_cnt_even", spike_cnt[0*IDX_W +: IDX_W], 0);
        drain_all("t6_done");
`endif

        // randomized traffic with occasional clear
        for (int i = 0; i < 3000; i++) begin
            din   = DATA_W'($urandom);
            din_v = ($urandom_range(9) < 6);
            rdy   = $urandom_range(1);
            clear = ($urandom_range(149) == 0);
            @(negedge clk);
        end
        din_v = 1'b0;
        clear = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
